dummy_dac_burst: RTL and testbench

Parametrised emulator for a DAC slot that has no real converter. It drains the slot FIFO in fixed-size sample bursts at a programmable sample rate and drives the low bits of each byte onto the tristated slot data bus. Unlike the first-generation dummy, it checks FIFO fill before each burst, supports mono and stereo burst lengths, and reports underruns and overruns. It sits between the slot FIFO and the FX2 slot data pins.

---
 rtl/dummy_dac_burst.sv | 176 +++++++++++++++++
 tb/tb_dummy_dac_burst.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/dummy_dac_burst.sv
// dummy_dac_burst
//   Stand-in for a DAC slot with no converter fitted. Once per sample period
//   it checks the slot FIFO fill level and, if a whole burst is present,
//   reads a mono or stereo burst of bytes. The low DATA_WIDTH bits of each
//   byte are presented on the tristated slot data bus.
//
//   Optional: define DUMMY_DAC_CHECKSUM_EN to add a running 8-bit checksum
//   output covering every full byte captured from the FIFO.
//
// Ports
//   clk             system clock (100 MHz)
//   reset           asynchronous active-low reset
//   fifo_clk        sample-rate clock to the FIFO, period CLK_DIV
//   fifo_data       FIFO read data, valid the cycle after fifo_read
//   fifo_read       FIFO read strobe, one byte per cycle
//   fifo_addr_in    FIFO write pointer
//   fifo_addr_out   FIFO read pointer
//   slot_data       slot data bus, driven only while direction==0
//   direction       0 = DAC (drive slot_data), 1 = ADC (Hi-Z)
//   channels        0 = mono, 1 = stereo
//   byte_valid      one-cycle pulse; data_out loads at the end of it
//   underrun_count  saturating count of bursts skipped for lack of data
//   overrun         sticky: a sample tick arrived while a burst was active
//   checksum        (DUMMY_DAC_CHECKSUM_EN only) byte sum modulo 256
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for the sample tick
// CHECK   | compare fill level to burst length, count underruns
// READ    | fifo_read high, byte counter counts down to the last read
// DRAIN   | last byte arrives from the FIFO and is captured

module dummy_dac_burst #(
  parameter int DATA_WIDTH       = 6,
  parameter int FIFO_ADDR_WIDTH  = 11,
  parameter int CLK_DIV          = 256,
  parameter int BYTES_PER_SAMPLE = 4,
  parameter int UNDERRUN_WIDTH   = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       fifo_clk,
  input  logic [7:0]                 fifo_data,
  output logic                       fifo_read,
  input  logic [FIFO_ADDR_WIDTH-1:0] fifo_addr_in,
  input  logic [FIFO_ADDR_WIDTH-1:0] fifo_addr_out,
  inout  wire  [DATA_WIDTH-1:0]      slot_data,
  input  logic                       direction,
  input  logic                       channels,
  output logic                       byte_valid,
  output logic [UNDERRUN_WIDTH-1:0]  underrun_count,
  output logic                       overrun
`ifdef DUMMY_DAC_CHECKSUM_EN
  ,
  output logic [7:0]                 checksum
`endif
);

  localparam int DIV_W  = $clog2(CLK_DIV);
  localparam int BCNT_W = $clog2(2*BYTES_PER_SAMPLE + 1);

  localparam logic [DIV_W-1:0]  DIV_HALF   = DIV_W'(CLK_DIV/2 - 1);
  localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [BCNT_W-1:0] LEN_MONO   = BCNT_W'(BYTES_PER_SAMPLE);
  localparam logic [BCNT_W-1:0] LEN_STEREO = BCNT_W'(2*BYTES_PER_SAMPLE);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CHECK = 2'd1;
  localparam logic [1:0] S_READ  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [DIV_W-1:0]           div_cnt;
  logic                       tick;
  logic [1:0]                 state;
  logic [BCNT_W-1:0]          byte_cnt;
  logic [DATA_WIDTH-1:0]      data_out;
  logic [FIFO_ADDR_WIDTH-1:0] level;
  logic [BCNT_W-1:0]          burst_len;
  logic                       burst_ok;

  // Unsigned modular subtraction absorbs pointer wrap.
  assign level     = fifo_addr_in - fifo_addr_out;
  assign burst_len = channels ? LEN_STEREO : LEN_MONO;
  assign burst_ok  = 32'(level) >= 32'(burst_len);

  assign fifo_read = (state == S_READ);
  assign slot_data = direction ? {DATA_WIDTH{1'bz}} : data_out;

  // Sample-rate divider. The tick is registered so the FSM sees it the
  // edge after fifo_clk rises, putting the first read two edges later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt  <= '0;
      fifo_clk <= 1'b0;
      tick     <= 1'b0;
    end else begin
      tick <= (div_cnt == DIV_HALF);
      if (div_cnt == DIV_HALF)
        fifo_clk <= 1'b1;
      else if (div_cnt == DIV_LAST)
        fifo_clk <= 1'b0;
      if (div_cnt == DIV_LAST)
        div_cnt <= '0;
      else
        div_cnt <= div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= S_IDLE;
      byte_cnt       <= '0;
      underrun_count <= '0;
      overrun        <= 1'b0;
    end else begin
      // A tick during a burst is dropped; the burst itself carries on.
      if (tick && (state != S_IDLE))
        overrun <= 1'b1;

      case (state)
        S_IDLE: begin
          if (tick)
            state <= S_CHECK;
        end
        S_CHECK: begin
          if (burst_ok) begin
            byte_cnt <= burst_len;
            state    <= S_READ;
          end else begin
            if (underrun_count != {UNDERRUN_WIDTH{1'b1}})
              underrun_count <= underrun_count + 1'b1;
            state <= S_IDLE;
          end
        end
        S_READ: begin
          byte_cnt <= byte_cnt - 1'b1;
          if (byte_cnt == BCNT_W'(1))
            state <= S_DRAIN;
        end
        S_DRAIN: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // byte_valid marks the cycle in which the FIFO presents the byte from the
  // previous read; the byte is loaded into data_out at the end of it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byte_valid <= 1'b0;
      data_out   <= '0;
    end else begin
      byte_valid <= fifo_read;
      if (byte_valid)
        data_out <= fifo_data[DATA_WIDTH-1:0];
    end
  end

`ifdef DUMMY_DAC_CHECKSUM_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      checksum <= 8'h00;
    else if (byte_valid)
      checksum <= checksum + fifo_data;
  end
`else
  // Upper byte bits only matter to the checksum.
  logic [7:0] unused_fifo_data;
  assign unused_fifo_data = fifo_data;
`endif

endmodule

// File: tb/tb_dummy_dac_burst.sv
// tb_dummy_dac_burst
//   Directed bench for dummy_dac_burst. A small FIFO model answers reads one
//   cycle later; each observation window spans one sample period aligned to
//   the divider so it contains exactly one sample tick.

module tb_dummy_dac_burst;

  localparam int DW  = 6;
  localparam int AW  = 11;
  // Shorter sample period keeps the 300-period saturation run brief.
  localparam int DIV = 64;
  localparam int BPS = 4;
  localparam int UW  = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          fifo_clk;
  logic [7:0]    fifo_data = 8'h00;
  logic          fifo_read;
  logic [AW-1:0] fifo_addr_in = '0;
  logic [AW-1:0] fifo_addr_out = '0;
  wire  [DW-1:0] slot_data;
  logic          direction = 1'b0;
  logic          channels = 1'b0;
  logic          byte_valid;
  logic [UW-1:0] underrun_count;
  logic          overrun;
`ifdef DUMMY_DAC_CHECKSUM_EN
  logic [7:0]    checksum;
  logic [7:0]    csum2;
`endif

  // ADC side of the bus: drives zeros whenever the DAC should be Hi-Z.
  assign slot_data = direction ? '0 : 'z;

  dummy_dac_burst #(
    .DATA_WIDTH(DW), .FIFO_ADDR_WIDTH(AW), .CLK_DIV(DIV),
    .BYTES_PER_SAMPLE(BPS), .UNDERRUN_WIDTH(UW)
  ) dut (
    .clk(clk), .reset(reset), .fifo_clk(fifo_clk), .fifo_data(fifo_data),
    .fifo_read(fifo_read), .fifo_addr_in(fifo_addr_in),
    .fifo_addr_out(fifo_addr_out), .slot_data(slot_data),
    .direction(direction), .channels(channels), .byte_valid(byte_valid),
    .underrun_count(underrun_count), .overrun(overrun)
`ifdef DUMMY_DAC_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:15];
  logic [3:0] rd_ptr = 4'd0;
  logic       ptr_clr = 1'b0;

  always @(posedge clk) begin
    if (ptr_clr)
      rd_ptr <= 4'd0;
    else if (fifo_read) begin
      fifo_data <= mem[rd_ptr];
      rd_ptr    <= rd_ptr + 4'd1;
    end
  end

  int n_vec = 0;
  int n_bad = 0;

  int n_rd, n_bv, n_cap, first_clk, first_rd, first_bv;
  logic [DW-1:0] cap [0:15];
  logic prev_bv;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Watch n cycles; edge numbers are counted from the start of the window.
  task automatic observe(input int n);
    n_rd = 0; n_bv = 0; n_cap = 0;
    first_clk = -1; first_rd = -1; first_bv = -1;
    prev_bv = 1'b0;
    ptr_clr = 1'b1;
    for (int e = 1; e <= n; e++) begin
      @(negedge clk);
      ptr_clr = 1'b0;
      if (prev_bv) begin
        if (n_cap < 16) cap[n_cap] = slot_data;
        n_cap++;
`ifdef DUMMY_DAC_CHECKSUM_EN
        if (n_cap == 2) csum2 = checksum;
`endif
      end
      if (fifo_clk && first_clk < 0) first_clk = e;
      if (fifo_read && first_rd < 0) first_rd = e;
      if (byte_valid && first_bv < 0) first_bv = e;
      if (fifo_read) n_rd++;
      if (byte_valid) n_bv++;
      prev_bv = byte_valid;
    end
  endtask

  int nonzero;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'(i + 1);

    #2 reset = 1'b0;
    #1;
    check_val("rst_fifo_clk", 32'(fifo_clk), 0);
    check_val("rst_fifo_read", 32'(fifo_read), 0);
    check_val("rst_byte_valid", 32'(byte_valid), 0);
    check_val("rst_underrun", 32'(underrun_count), 0);
    check_val("rst_overrun", 32'(overrun), 0);
    check_val("rst_slot_data", 32'(slot_data), 0);
`ifdef DUMMY_DAC_CHECKSUM_EN
    check_val("rst_checksum", 32'(checksum), 0);
`endif
    repeat (3) @(negedge clk);

    // 1: mono, level 16
    fifo_addr_in = 11'd16; fifo_addr_out = 11'd0; channels = 1'b0;
    reset = 1'b1;
    observe(DIV);
    check_val("t1_fifo_clk_rise", 32'(first_clk), DIV/2);
    check_val("t1_first_read", 32'(first_rd), DIV/2 + 2);
    check_val("t1_first_bv", 32'(first_bv), DIV/2 + 3);
    check_val("t1_n_read", 32'(n_rd), 4);
    check_val("t1_n_bv", 32'(n_bv), 4);
    check_val("t1_n_cap", 32'(n_cap), 4);
    for (int i = 0; i < 4; i++)
      check_val($sformatf("t1_data%0d", i), 32'(cap[i]), i + 1);
    check_val("t1_fifo_clk_fall", 32'(fifo_clk), 0);
    check_val("t1_underrun", 32'(underrun_count), 0);

    // 2: stereo level 8, then level 7
    channels = 1'b1; fifo_addr_in = 11'd8;
    observe(DIV);
    check_val("t2_n_read", 32'(n_rd), 8);
    check_val("t2_n_bv", 32'(n_bv), 8);
    check_val("t2_data0", 32'(cap[0]), 1);
    check_val("t2_data7", 32'(cap[7]), 8);
    check_val("t2_underrun0", 32'(underrun_count), 0);
    fifo_addr_in = 11'd7;
    observe(DIV);
    check_val("t2_l7_n_read", 32'(n_rd), 0);
    check_val("t2_l7_n_bv", 32'(n_bv), 0);
    check_val("t2_l7_underrun1", 32'(underrun_count), 1);
    observe(DIV);
    check_val("t2_l7_underrun2", 32'(underrun_count), 2);

    // 3: pointer wrap, level 6
    fifo_addr_in = 11'h002; fifo_addr_out = 11'h7FC; channels = 1'b0;
    observe(DIV);
    check_val("t3_mono_n_read", 32'(n_rd), 4);
    check_val("t3_mono_underrun", 32'(underrun_count), 2);
    channels = 1'b1;
    observe(DIV);
    check_val("t3_stereo_n_read", 32'(n_rd), 0);
    check_val("t3_stereo_underrun", 32'(underrun_count), 3);

    // 4: saturation (3 + 252 = 255, then 48 more periods)
    observe(DIV * 252);
    check_val("t4_underrun_255", 32'(underrun_count), 255);
    observe(DIV * 48);
    check_val("t4_underrun_sat", 32'(underrun_count), 255);
    check_val("t4_overrun", 32'(overrun), 0);

    // 5: ADC direction, DAC must release the bus
    fifo_addr_in = 11'd16; fifo_addr_out = 11'd0; channels = 1'b0;
    direction = 1'b1;
    observe(DIV);
    check_val("t5_n_read", 32'(n_rd), 4);
    check_val("t5_n_bv", 32'(n_bv), 4);
    nonzero = 0;
    for (int i = 0; i < 4; i++)
      if (cap[i] != '0) nonzero++;
    check_val("t5_bus_released", 32'(nonzero), 0);
    direction = 1'b0;
    #1;
    check_val("t5_bus_redriven", 32'(slot_data), 4);

    // 6: reset during READ after two reads
    mem[0] = 8'hFF;
    observe(DIV/2 + 4);
    check_val("t6_pre_read", 32'(fifo_read), 1);
    check_val("t6_pre_data", 32'(slot_data), 32'h3F);
    reset = 1'b0;
    #1;
    check_val("t6_rst_read", 32'(fifo_read), 0);
    check_val("t6_rst_data", 32'(slot_data), 0);
    check_val("t6_rst_fifo_clk", 32'(fifo_clk), 0);
    check_val("t6_rst_underrun", 32'(underrun_count), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    observe(DIV);
    check_val("t6_first_read", 32'(first_rd), DIV/2 + 2);
    check_val("t6_n_read", 32'(n_rd), 4);
    check_val("t6_data0", 32'(cap[0]), 32'h3F);
    check_val("t6_data1", 32'(cap[1]), 32'h02);
    check_val("t6_data3", 32'(cap[3]), 32'h04);
`ifdef DUMMY_DAC_CHECKSUM_EN
    check_val("t6_checksum_ff_02", 32'(csum2), 32'h01);
    check_val("t6_checksum_burst", 32'(checksum), 32'h08);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
